// File: rtl/regfile_op_sequencer.sv
// Multi-cycle, non-pipelined sequencer that reads two registers, runs one ALU
// operation and writes the result back to an external register file.
module regfile_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [ADDR_WIDTH-1:0] instr_rd,
    input  logic [ADDR_WIDTH-1:0] instr_rs1,
    input  logic [ADDR_WIDTH-1:0] instr_rs2,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_1,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_2,
    input  logic [DATA_WIDTH-1:0] rf_read_data_1,
    input  logic [DATA_WIDTH-1:0] rf_read_data_2,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_dest,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_MOV  = 3'b111
    } op_t;

    state_t                state;
    state_t                next_state;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   alu_result;
    logic                  alu_zero;
    logic                  accept;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = READ;
            READ:    next_state = EXEC;
            EXEC:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bit DATA_WIDTH of the ALU result carries carry, borrow or the shifted-out bit.
    always_comb begin
        alu_result = '0;
        case (op_q)
            OP_ADD:  alu_result = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_result = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_result = {1'b0, op_a & op_b};
            OP_OR:   alu_result = {1'b0, op_a | op_b};
            OP_XOR:  alu_result = {1'b0, op_a ^ op_b};
            OP_SHL1: alu_result = {op_a, 1'b0};
            OP_SHR1: alu_result = {op_a[0], 1'b0, op_a[DATA_WIDTH-1:1]};
            OP_MOV:  alu_result = {1'b0, op_a};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result[DATA_WIDTH-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            rf_write_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            instr_ready <= (next_state == IDLE);
            busy        <= (next_state != IDLE);
            rf_write_en <= (next_state == WRITE);
            done        <= (next_state == WRITE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q           <= OP_ADD;
            rd_q           <= '0;
            rf_read_addr_1 <= '0;
            rf_read_addr_2 <= '0;
        end else if (state == IDLE && accept) begin
            op_q           <= op_t'(instr_op);
            rd_q           <= instr_rd;
            rf_read_addr_1 <= instr_rs1;
            rf_read_addr_2 <= instr_rs2;
        end
    end

    // Operands are captured here, so a destination equal to a source is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (state == READ) begin
            op_a <= rf_read_data_1;
            op_b <= rf_read_data_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_dest <= '0;
            rf_write_data <= '0;
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
        end else if (state == EXEC) begin
            rf_write_dest <= rd_q;
            rf_write_data <= alu_result[DATA_WIDTH-1:0];
            flag_zero     <= alu_zero;
            flag_carry    <= alu_result[DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: an 8x8 register file around the DUT and an
// arithmetic reference model of the instruction set.
module tb_regfile_op_sequencer;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic [2:0] rf_read_addr_1;
    logic [2:0] rf_read_addr_2;
    logic [7:0] rf_read_data_1;
    logic [7:0] rf_read_data_2;
    logic       rf_write_en;
    logic [2:0] rf_write_dest;
    logic [7:0] rf_write_data;
    logic       busy;
    logic       done;
    logic       flag_zero;
    logic       flag_carry;

    logic       pre_en;
    logic [2:0] pre_addr;
    logic [7:0] pre_val;
    logic [7:0] rf_mem [8];
    int         ref_regs [8];
    int         n_checks;
    int         n_fail;

    typedef struct {
        int         lat;
        int         nwr;
        logic [7:0] data;
        logic [2:0] dest;
        logic       zf;
        logic       cf;
        logic       zf_end;
        logic       cf_end;
        logic [6:1] rdy;
        logic [6:1] bsy;
        logic       done_ok;
        logic [2:0] a1;
        logic [2:0] a2;
    } obs_t;

    regfile_op_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest),
        .rf_write_data(rf_write_data), .busy(busy), .done(done),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: resets with the sequencer to r0=1, r1=2, others 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= (i == 0) ? 8'd1 : (i == 1) ? 8'd2 : 8'd0;
        end else if (pre_en) begin
            rf_mem[pre_addr] <= pre_val;
        end else if (rf_write_en) begin
            rf_mem[rf_write_dest] <= rf_write_data;
        end
    end

    assign rf_read_data_1 = rf_mem[rf_read_addr_1];
    assign rf_read_data_2 = rf_mem[rf_read_addr_2];

    // Reference model: returns {carry, result[7:0]}.
    function automatic logic [8:0] ref_exec(input int op, input int a, input int b);
        int   r;
        logic c;
        r = 0;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b); if (r < 0) r = r + 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * 2; c = (a >= 128); end
            6: begin r = a / 2; c = (a % 2) == 1; end
            default: r = a;
        endcase
        r = r % 256;
        return {c, r[7:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        pre_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = (i == 0) ? 1 : (i == 1) ? 2 : 0;
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] val);
        @(negedge clk);
        pre_en = 1'b1;
        pre_addr = addr;
        pre_val = val;
        @(posedge clk);
        @(negedge clk);
        pre_en = 1'b0;
        ref_regs[addr] = int'(val);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2, output obs_t o);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = op;
        instr_rd = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        @(posedge clk);
        o.lat = -1; o.nwr = 0; o.done_ok = 1'b1; o.rdy = '0; o.bsy = '0;
        o.data = '0; o.dest = '0; o.zf = 1'b0; o.cf = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                instr_valid = 1'b0;
                o.a1 = rf_read_addr_1;
                o.a2 = rf_read_addr_2;
            end
            o.rdy[k] = instr_ready;
            o.bsy[k] = busy;
            if (done !== rf_write_en) o.done_ok = 1'b0;
            if (rf_write_en === 1'b1) begin
                o.nwr++;
                if (o.lat < 0) begin
                    o.lat = k; o.data = rf_write_data; o.dest = rf_write_dest;
                    o.zf = flag_zero; o.cf = flag_carry;
                end
            end
        end
        o.zf_end = flag_zero;
        o.cf_end = flag_carry;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", instr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({rf_write_en, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_we_done: got %b expected 00", {rf_write_en, done}); end
        n_checks++; if ({rf_read_addr_1, rf_read_addr_2, rf_write_dest, rf_write_data} !== 17'h0) begin
            n_fail++; $display("[TB] FAIL reset_addr_data: got %h expected 0", {rf_read_addr_1, rf_read_addr_2, rf_write_dest, rf_write_data}); end
        n_checks++; if ({flag_zero, flag_carry} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00", {flag_zero, flag_carry}); end
        do_reset();
    endtask

    task automatic test_add();
        obs_t o;
        logic [8:0] e;
        do_reset();
        e = ref_exec(0, ref_regs[0], ref_regs[1]);
        run_instr(3'b000, 3'd2, 3'd0, 3'd1, o);
        ref_regs[2] = int'(e[7:0]);
        n_checks++; if (o.lat !== 3 || o.nwr !== 1) begin n_fail++; $display("[TB] FAIL add_latency: got lat=%0d writes=%0d expected lat=3 writes=1", o.lat, o.nwr); end
        n_checks++; if (o.dest !== 3'd2 || o.data !== e[7:0]) begin n_fail++; $display("[TB] FAIL add_write: got r%0d=%h expected r2=%h", o.dest, o.data, e[7:0]); end
        n_checks++; if ({o.zf, o.cf} !== 2'b00) begin n_fail++; $display("[TB] FAIL add_flags: got %b expected 00", {o.zf, o.cf}); end
        n_checks++; if (o.rdy !== 6'b111000 || o.bsy !== 6'b000111) begin n_fail++; $display("[TB] FAIL add_ready_busy: got rdy=%b busy=%b expected 111000/000111", o.rdy, o.bsy); end
        n_checks++; if (o.a1 !== 3'd0 || o.a2 !== 3'd1) begin n_fail++; $display("[TB] FAIL add_read_addr: got %0d,%0d expected 0,1", o.a1, o.a2); end
        n_checks++; if (!o.done_ok) begin n_fail++; $display("[TB] FAIL add_done: got done differing from write_en expected equal"); end
        n_checks++; if (rf_mem[2] !== 8'd3) begin n_fail++; $display("[TB] FAIL add_rf: got %h expected 03", rf_mem[2]); end
    endtask

    task automatic test_sub();
        obs_t o;
        logic [8:0] e;
        logic [2:0] rd_t [2] = '{3'd3, 3'd4};
        logic [2:0] rs1_t [2] = '{3'd0, 3'd1};
        logic [8:0] want [2] = '{9'h1FF, 9'h000};
        for (int i = 0; i < 2; i++) begin
            e = ref_exec(1, ref_regs[rs1_t[i]], ref_regs[1]);
            run_instr(3'b001, rd_t[i], rs1_t[i], 3'd1, o);
            ref_regs[rd_t[i]] = int'(e[7:0]);
            n_checks++; if (e !== want[i]) begin n_fail++; $display("[TB] FAIL sub_model%0d: got %h expected %h", i, e, want[i]); end
            n_checks++; if (o.lat !== 3 || o.data !== e[7:0] || o.dest !== rd_t[i]) begin
                n_fail++; $display("[TB] FAIL sub_write%0d: got lat=%0d r%0d=%h expected lat=3 r%0d=%h", i, o.lat, o.dest, o.data, rd_t[i], e[7:0]); end
            n_checks++; if (o.cf !== e[8] || o.zf !== (e[7:0] == 8'h0)) begin
                n_fail++; $display("[TB] FAIL sub_flags%0d: got z=%b c=%b expected z=%b c=%b", i, o.zf, o.cf, e[7:0] == 8'h0, e[8]); end
            n_checks++; if (o.cf_end !== e[8] || o.zf_end !== (e[7:0] == 8'h0)) begin
                n_fail++; $display("[TB] FAIL sub_flag_hold%0d: got z=%b c=%b expected z=%b c=%b", i, o.zf_end, o.cf_end, e[7:0] == 8'h0, e[8]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc [3] = '{-100, -100, -100};
        int wr [3] = '{-100, -100, -100};
        int idx = 0;
        int nw = 0;
        logic rdy;
        logic exp_busy;
        logic exp_we;
        logic [8:0] e;
        logic [2:0] q_op [3] = '{3'b000, 3'b001, 3'b100};
        logic [2:0] q_rd [3] = '{3'd2, 3'd3, 3'd4};
        logic [2:0] q_s1 [3] = '{3'd0, 3'd1, 3'd0};
        logic [2:0] q_s2 [3] = '{3'd1, 3'd0, 3'd2};
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (idx < 3) begin
                instr_valid = 1'b1; instr_op = q_op[idx]; instr_rd = q_rd[idx];
                instr_rs1 = q_s1[idx]; instr_rs2 = q_s2[idx];
            end else begin
                instr_valid = 1'b0;
            end
            rdy = instr_ready;
            @(posedge clk);
            if (rdy && instr_valid && idx < 3) begin acc[idx] = c; idx++; end
            @(negedge clk);
            exp_busy = 1'b0; exp_we = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (c - acc[j] >= 0 && c - acc[j] <= 2) exp_busy = 1'b1;
                if (c - acc[j] == 2) exp_we = 1'b1;
            end
            n_checks++; if (busy !== exp_busy || instr_ready !== !exp_busy || rf_write_en !== exp_we) begin
                n_fail++; $display("[TB] FAIL b2b_cycle%0d: got busy=%b ready=%b we=%b expected %b/%b/%b", c, busy, instr_ready, rf_write_en, exp_busy, !exp_busy, exp_we); end
            if (rf_write_en === 1'b1 && nw < 3) begin
                e = ref_exec(int'(q_op[nw]), ref_regs[q_s1[nw]], ref_regs[q_s2[nw]]);
                ref_regs[q_rd[nw]] = int'(e[7:0]);
                wr[nw] = c;
                n_checks++; if (rf_write_data !== e[7:0] || rf_write_dest !== q_rd[nw]) begin
                    n_fail++; $display("[TB] FAIL b2b_write%0d: got r%0d=%h expected r%0d=%h", nw, rf_write_dest, rf_write_data, q_rd[nw], e[7:0]); end
                nw++;
            end
        end
        n_checks++; if (idx !== 3 || nw !== 3) begin n_fail++; $display("[TB] FAIL b2b_count: got accepts=%0d writes=%0d expected 3/3", idx, nw); end
        n_checks++; if (wr[1] - wr[0] !== 4 || wr[2] - wr[1] !== 4) begin
            n_fail++; $display("[TB] FAIL b2b_spacing: got %0d,%0d expected 4,4", wr[1] - wr[0], wr[2] - wr[1]); end
        n_checks++; if (int'(rf_mem[4]) !== ref_regs[4]) begin n_fail++; $display("[TB] FAIL b2b_rf: got %h expected %h", rf_mem[4], ref_regs[4]); end
    endtask

    task automatic test_dependent();
        obs_t o;
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? ref_exec(0, ref_regs[0], ref_regs[1]) : ref_exec(0, ref_regs[2], ref_regs[2]);
            if (i == 0) run_instr(3'b000, 3'd2, 3'd0, 3'd1, o);
            else        run_instr(3'b000, 3'd2, 3'd2, 3'd2, o);
            ref_regs[2] = int'(e[7:0]);
            n_checks++; if (o.lat !== 3 || o.data !== e[7:0] || o.dest !== 3'd2) begin
                n_fail++; $display("[TB] FAIL dep_write%0d: got lat=%0d r%0d=%h expected lat=3 r2=%h", i, o.lat, o.dest, o.data, e[7:0]); end
        end
        n_checks++; if (rf_mem[2] !== 8'd6) begin n_fail++; $display("[TB] FAIL dep_result: got %h expected 06", rf_mem[2]); end
    endtask

    task automatic test_shift();
        obs_t o;
        logic [8:0] e;
        logic [2:0] t_op [3] = '{3'b111, 3'b101, 3'b110};
        logic [2:0] t_rd [3] = '{3'd5, 3'd5, 3'd4};
        logic [2:0] t_s1 [3] = '{3'd7, 3'd5, 3'd3};
        logic [8:0] want [3] = '{9'h080, 9'h100, 9'h140};
        do_reset();
        preload(3'd7, 8'h80);
        preload(3'd3, 8'h81);
        for (int i = 0; i < 3; i++) begin
            e = ref_exec(int'(t_op[i]), ref_regs[t_s1[i]], ref_regs[0]);
            run_instr(t_op[i], t_rd[i], t_s1[i], 3'd0, o);
            ref_regs[t_rd[i]] = int'(e[7:0]);
            n_checks++; if (e !== want[i]) begin n_fail++; $display("[TB] FAIL shift_model%0d: got %h expected %h", i, e, want[i]); end
            n_checks++; if (o.lat !== 3 || o.data !== e[7:0] || o.dest !== t_rd[i]) begin
                n_fail++; $display("[TB] FAIL shift_write%0d: got lat=%0d r%0d=%h expected lat=3 r%0d=%h", i, o.lat, o.dest, o.data, t_rd[i], e[7:0]); end
            n_checks++; if (o.cf !== e[8] || o.zf !== (e[7:0] == 8'h0)) begin
                n_fail++; $display("[TB] FAIL shift_flags%0d: got z=%b c=%b expected z=%b c=%b", i, o.zf, o.cf, e[7:0] == 8'h0, e[8]); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [8:0] e;
        logic [2:0] op, rd, s1, s2;
        do_reset();
        for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
            s1 = 3'($urandom_range(0, 7)); s2 = 3'($urandom_range(0, 7));
            e = ref_exec(int'(op), ref_regs[s1], ref_regs[s2]);
            run_instr(op, rd, s1, s2, o);
            ref_regs[rd] = int'(e[7:0]);
            n_checks++; if (o.lat !== 3 || o.nwr !== 1 || o.dest !== rd || o.data !== e[7:0] || !o.done_ok) begin
                n_fail++; $display("[TB] FAIL rand_write%0d: op=%0d got lat=%0d n=%0d r%0d=%h expected lat=3 n=1 r%0d=%h", n, op, o.lat, o.nwr, o.dest, o.data, rd, e[7:0]); end
            n_checks++; if (o.cf !== e[8] || o.zf !== (e[7:0] == 8'h0)) begin
                n_fail++; $display("[TB] FAIL rand_flags%0d: op=%0d got z=%b c=%b expected z=%b c=%b", n, op, o.zf, o.cf, e[7:0] == 8'h0, e[8]); end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (int'(rf_mem[i]) !== ref_regs[i]) begin n_fail++; $display("[TB] FAIL rand_rf%0d: got %h expected %h", i, rf_mem[i], ref_regs[i]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int writes = 0;
        do_reset();
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 3'd6; instr_rs1 = 3'd0; instr_rs2 = 3'd1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1 || rf_write_en !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_immediate: got busy=%b ready=%b we=%b expected 0/1/0", busy, instr_ready, rf_write_en); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rf_write_en !== 1'b0 || done !== 1'b0) writes++;
            if (k == 0) begin
                n_checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL abort_idle: got busy=%b ready=%b expected 0/1", busy, instr_ready); end
            end
        end
        n_checks++; if (writes !== 0) begin n_fail++; $display("[TB] FAIL abort_no_write: got %0d write cycles expected 0", writes); end
        n_checks++; if (rf_mem[6] !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_r6: got %h expected 00", rf_mem[6]); end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        pre_en = 1'b0; pre_addr = '0; pre_val = '0;
        n_checks = 0;
        n_fail = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_dependent();
        test_shift();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
